// File: rtl/round_robin_arbiter.sv
// Round-robin / fixed-priority arbiter with a registered valid/ready grant.
// The cyclic priority search rotates the request vector to the search start,
// then finds the first set bit with a two-level tree of SPLIT groups.
//
// Handshake: gnt_vld is asserted while a grant is outstanding and stays
// stable until the cycle where gnt_vld & gnt_rdy are both high. That cycle
// is the transfer. Unless lock holds the grant, the same cycle re-arbitrates,
// so the next grant appears on the following edge with no idle bubble.
module round_robin_arbiter #(
    parameter int WIDTH = 4,
    parameter int SPLIT = 2,
    localparam int WIDTH_LOG = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     req,
    input  logic                 mode,
    input  logic [WIDTH_LOG-1:0] pri_fix,
    input  logic                 lock,
    output logic                 gnt_vld,
    input  logic                 gnt_rdy,
    output logic [WIDTH_LOG-1:0] gnt_idx,
    output logic [WIDTH-1:0]     gnt_oht,
    output logic [WIDTH_LOG-1:0] ptr
);

    localparam int GW = WIDTH / SPLIT;

    localparam logic STATE_IDLE  = 1'b0;
    localparam logic STATE_GRANT = 1'b1;

    // The FSM state doubles as the grant-valid flag.
    logic                 state;
    logic                 handshake;
    logic                 hold_lock;
    logic                 arb;
    logic [WIDTH_LOG-1:0] next_ptr;
    logic [WIDTH_LOG-1:0] start;
    logic [WIDTH_LOG:0]   start_ext;
    logic [2*WIDTH-1:0]   req_dbl;
    logic [WIDTH-1:0]     rot;
    logic [GW-1:0]        grp_bits;
    logic                 found;
    int                   grp_i;
    int                   bit_i;
    logic [WIDTH_LOG-1:0] offset;
    logic [WIDTH_LOG-1:0] winner;
    logic [WIDTH-1:0]     win_oht;

    assign gnt_vld = (state == STATE_GRANT);

    // Decide whether this cycle arbitrates and what the pointer becomes.
    always_comb begin
        handshake = (state == STATE_GRANT) && gnt_rdy;
        // A locked transfer keeps the grant only while its requester still asks.
        hold_lock = handshake && lock && req[gnt_idx];
        arb       = (state == STATE_IDLE) || (handshake && !hold_lock);
        next_ptr  = ptr;
        if (handshake && !hold_lock && !mode) begin
            next_ptr = gnt_idx + 1'b1;
        end
        // Back-to-back arbitration already uses the advanced pointer.
        start     = mode ? pri_fix : next_ptr;
        start_ext = {1'b0, start};
    end

    // Rotate requests so bit 0 is the search start; wrap-around comes for free.
    always_comb begin
        req_dbl = {req, req};
        rot     = req_dbl[start_ext +: WIDTH];
    end

    // Tree search, lowest offset wins. Scanning from high to low lets the
    // winner overwrite anything later in search order, so an unknown request
    // after the winner cannot reach the result.
    always_comb begin
        found    = 1'b0;
        grp_i    = 0;
        grp_bits = '0;
        for (int g = SPLIT - 1; g >= 0; g--) begin
            if (|rot[g*GW +: GW]) begin
                found    = 1'b1;
                grp_i    = g;
                grp_bits = rot[g*GW +: GW];
            end
        end
        bit_i = 0;
        for (int b = GW - 1; b >= 0; b--) begin
            if (grp_bits[b]) begin
                bit_i = b;
            end
        end
        offset  = WIDTH_LOG'(grp_i * GW + bit_i);
        winner  = start + offset;
        win_oht = WIDTH'(1) << winner;
    end

    // Registered grant state, pointer and outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= STATE_IDLE;
            gnt_idx <= '0;
            gnt_oht <= '0;
            ptr     <= '0;
        end else begin
            ptr <= next_ptr;
            if (arb) begin
                if (found) begin
                    state   <= STATE_GRANT;
                    gnt_idx <= winner;
                    gnt_oht <= win_oht;
                end else begin
                    state   <= STATE_IDLE;
                    gnt_oht <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Directed bench for round_robin_arbiter (WIDTH=4, SPLIT=2).
// Inputs change 1 time unit after a rising edge; outputs are checked there.
module tb_round_robin_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       mode;
    logic [1:0] pri_fix;
    logic       lock;
    logic       gnt_vld;
    logic       gnt_rdy;
    logic [1:0] gnt_idx;
    logic [3:0] gnt_oht;
    logic [1:0] ptr;

    int total = 0;
    int bad   = 0;

    round_robin_arbiter #(.WIDTH(4), .SPLIT(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .mode    (mode),
        .pri_fix (pri_fix),
        .lock    (lock),
        .gnt_vld (gnt_vld),
        .gnt_rdy (gnt_rdy),
        .gnt_idx (gnt_idx),
        .gnt_oht (gnt_oht),
        .ptr     (ptr)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks the whole grant picture; one-hot is derived from the expected index.
    task automatic expect_grant(input string tag, input logic vld, input logic [1:0] idx,
                                input logic [1:0] p);
        logic [3:0] oht;
        oht = vld ? (4'b0001 << idx) : 4'b0000;
        check({tag, ".vld"}, 32'(gnt_vld), 32'(vld));
        check({tag, ".idx"}, 32'(gnt_idx), 32'(idx));
        check({tag, ".oht"}, 32'(gnt_oht), 32'(oht));
        check({tag, ".ptr"}, 32'(ptr), 32'(p));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        req     = 4'b0000;
        mode    = 1'b0;
        pri_fix = 2'd0;
        lock    = 1'b0;
        gnt_rdy = 1'b0;

        // Reset state
        step();
        step();
        expect_grant("reset", 1'b0, 2'd0, 2'd0);
        rst_n = 1'b1;

        // Round robin across all four requesters, back to back
        req = 4'b1111; gnt_rdy = 1'b1;
        step(); expect_grant("rr0", 1'b1, 2'd0, 2'd0);
        step(); expect_grant("rr1", 1'b1, 2'd1, 2'd1);
        step(); expect_grant("rr2", 1'b1, 2'd2, 2'd2);
        step(); expect_grant("rr3", 1'b1, 2'd3, 2'd3);
        step(); expect_grant("rr4", 1'b1, 2'd0, 2'd0);
        // No requests: back to idle, index held
        req = 4'b0000;
        step(); expect_grant("rr_idle", 1'b0, 2'd0, 2'd1);

        // Fixed priority: pointer untouched
        mode = 1'b1; pri_fix = 2'd2; req = 4'b1011;
        step(); expect_grant("fix_a", 1'b1, 2'd3, 2'd1);
        step(); expect_grant("fix_b", 1'b1, 2'd3, 2'd1);
        pri_fix = 2'd0;
        step(); expect_grant("fix_p0", 1'b1, 2'd0, 2'd1);
        req = 4'b0000;
        step(); expect_grant("fix_idle", 1'b0, 2'd0, 2'd1);
        mode = 1'b0;

        // Stall: grant held while gnt_rdy is low, even if req changes
        req = 4'b0110; gnt_rdy = 1'b0;
        step(); expect_grant("hold1", 1'b1, 2'd1, 2'd1);
        step(); expect_grant("hold2", 1'b1, 2'd1, 2'd1);
        req = 4'b0100;
        step(); expect_grant("hold3_drop", 1'b1, 2'd1, 2'd1);
        req = 4'b0111;
        step(); expect_grant("hold4_hi", 1'b1, 2'd1, 2'd1);
        req = 4'b0110;
        step(); expect_grant("hold5", 1'b1, 2'd1, 2'd1);
        step(); expect_grant("hold6", 1'b1, 2'd1, 2'd1);
        gnt_rdy = 1'b1;
        step(); expect_grant("hold_next", 1'b1, 2'd2, 2'd2);

        // Move the pointer to 1
        req = 4'b0000;
        step(); expect_grant("mv_a", 1'b0, 2'd2, 2'd3);
        req = 4'b0001;
        step(); expect_grant("mv_b", 1'b1, 2'd0, 2'd3);
        req = 4'b0000;
        step(); expect_grant("mv_c", 1'b0, 2'd0, 2'd1);

        // Lock keeps the grant across three transfers, wrap-around search
        req = 4'b1001; lock = 1'b1;
        step(); expect_grant("lock0", 1'b1, 2'd3, 2'd1);
        step(); expect_grant("lock1", 1'b1, 2'd3, 2'd1);
        step(); expect_grant("lock2", 1'b1, 2'd3, 2'd1);
        step(); expect_grant("lock3", 1'b1, 2'd3, 2'd1);
        lock = 1'b0;
        step(); expect_grant("unlock", 1'b1, 2'd0, 2'd0);
        // Lock without the holder requesting acts as a normal transfer
        req = 4'b1000; lock = 1'b1;
        step(); expect_grant("lock_drop", 1'b1, 2'd3, 2'd1);
        lock = 1'b0;

        // Get back to idle with pointer 1
        req = 4'b0000;
        step(); expect_grant("mv_d", 1'b0, 2'd3, 2'd0);
        req = 4'b0001;
        step(); expect_grant("mv_e", 1'b1, 2'd0, 2'd0);
        req = 4'b0000;
        step(); expect_grant("mv_f", 1'b0, 2'd0, 2'd1);

        // Unknown request after the winner does not leak
        req = 4'b1x10;
        step(); expect_grant("xreq", 1'b1, 2'd1, 2'd1);
        check("xreq.known", 32'($isunknown({gnt_vld, gnt_idx, gnt_oht, ptr})), 32'd0);

        // Asynchronous reset mid-grant
        req = 4'b1111;
        step(); expect_grant("pre_rst", 1'b1, 2'd2, 2'd2);
        #2 rst_n = 1'b0;
        #1 expect_grant("async_rst", 1'b0, 2'd0, 2'd0);
        #1 rst_n = 1'b1;
        // First edge after release arbitrates
        req = 4'b0100;
        step(); expect_grant("post_rst", 1'b1, 2'd2, 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
